// File: rtl/divider_pkg.sv
// divider_pkg: shared width, counter-width and FSM state definitions for the sequential divider.
package divider_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift, carry-select trial subtract, select).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    localparam int LO = (WIDTH + 1) / 2;
    localparam int HI = WIDTH + 1 - LO;
    logic [WIDTH:0] sh, nb, t;
    logic [LO:0]    lo;
    logic [HI-1:0]  hi0, hi1;
    assign sh = {r_i, q_i[WIDTH-1]};
    assign nb = ~{1'b0, divisor_i};
    // Upper half is precomputed for both carries so only a mux waits on the lower half.
    assign lo  = {1'b0, sh[LO-1:0]} + {1'b0, nb[LO-1:0]} + (LO+1)'(1);
    assign hi0 = sh[WIDTH:LO] + nb[WIDTH:LO];
    assign hi1 = hi0 + HI'(1);
    assign t   = {lo[LO] ? hi1 : hi0, lo[LO-1:0]};
    assign r_o = t[WIDTH] ? sh[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], ~t[WIDTH]};
endmodule

// File: rtl/seq_divider_32_bit.sv
// seq_divider_32_bit: multi-cycle unsigned restoring divider with valid/ready request and response.
module seq_divider_32_bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d, qw_q, qw_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [WIDTH-1:0] r_nx, qw_nx;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d, up_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i(r_q), .q_i(qw_q), .divisor_i(dvs_q), .r_o(r_nx), .q_o(qw_nx)
    );

    // up_q keeps in_ready low until the first edge after reset release.
    assign in_ready    = (state_q == IDLE) && up_q;
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        qw_d    = qw_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                dvs_d = divisor;
                if (divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = dividend;
                    dz_d    = 1'b1;
                end else begin
                    state_d = BUSY;
                    r_d     = '0;
                    qw_d    = dividend;
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                end
            end
            BUSY: begin
                r_d   = r_nx;
                qw_d  = qw_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = DONE;
                    quo_d   = qw_nx;
                    rem_d   = r_nx;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            qw_q    <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            qw_q    <= qw_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            up_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_divider_32_bit.sv
// tb_seq_divider_32_bit: directed vectors with a result scoreboard checked by an independent monitor.
module tb_seq_divider_32_bit;
    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          acc;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, div_by_zero;
    logic [31:0] dividend = '0, divisor = '0, quotient, remainder;
    exp_t        sb[$];
    int          n_pass = 0, n_tot = 0, cyc = 0, hs_cyc = 0;
    logic        ov_prev = 1'b0;

    seq_divider_32_bit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input logic ez, output int acc);
        int n = 0;
        exp_t e;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        e.q = eq; e.r = er; e.dz = ez; e.acc = acc;
        sb.push_back(e);
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) chk("result_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: checks latency on each new result, stability while stalled, and pops on handshake.
    initial forever begin
        @(negedge clk);
        if (!rst_n) ov_prev = 1'b0;
        else begin
            if (out_valid && sb.size() == 0) chk("unexpected_result", 64'(out_valid), 64'd0);
            else if (out_valid) begin
                if (!ov_prev)
                    chk("latency", 64'(sb[0].dz ? (cyc - sb[0].acc <= 1) : (cyc - sb[0].acc == 32)), 64'd1);
                chk("result", {quotient, remainder} ^ 64'(div_by_zero),
                    {sb[0].q, sb[0].r} ^ 64'(sb[0].dz));
                if (out_ready) begin
                    void'(sb.pop_front());
                    hs_cyc = cyc;
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        #12;
        chk("rst_outputs", {in_ready, out_valid, div_by_zero, quotient, remainder}, '0);
        #10 rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);
        send(9, 5, 1, 4, 1'b0, a1);
        wait_idle();
        send(900, 90, 10, 0, 1'b0, a1);
        send(265, 225, 1, 40, 1'b0, a2);
        chk("back_to_back_gap", 64'(a2 - hs_cyc), 64'd2);
        send(14, 0, 32'hFFFF_FFFF, 14, 1'b1, a1);
        send(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 1'b0, a1);
        send(200, 155, 1, 45, 1'b0, a1);
        send(0, 7, 0, 0, 1'b0, a1);
        send(3, 1000, 0, 3, 1'b0, a1);
        wait_idle();
        out_ready = 1'b0;
        send(355, 7, 50, 5, 1'b0, a1);
        while (!out_valid && cyc - a1 < 100) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            dividend = 32'(i * 17 + 3);
            divisor  = 32'(i + 2);
            chk("ready_in_done", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        send(1000, 3, 333, 1, 1'b0, a1);
        repeat (15) @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1 chk("async_reset", {in_ready, out_valid, div_by_zero, quotient, remainder}, '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(13, 14, 0, 13, 1'b0, a1);
        wait_idle();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
